// File: rtl/serdes_pkg.sv
// Shared symbols, frame geometry and link state encoding for the 10-bit transmit path.
// Pure declarations: no timing and no flow control of its own.
package serdes_pkg;
    localparam int SYM_W     = 10;
    localparam int FRAME_LEN = 10;
    localparam int SLOT_W    = $clog2(FRAME_LEN);

    localparam logic [SYM_W-1:0] COMMA_RDN = 10'b0011111010;
    localparam logic [SYM_W-1:0] COMMA_RDP = 10'b1100000101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAIN = 2'd1,
        RUN   = 2'd2
    } state_e;
endpackage

// File: rtl/serdes_tx_sched_rr_arbiter.sv
// Rotating-priority arbiter: purely combinational, zero latency.
// Never grants while enable is low; the grant is at most one-hot.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            found
);
    logic [PW:0]   sum;
    logic [PW-1:0] cand;

    // Walk candidates ptr, ptr+1, ... modulo NREQ; the first valid one wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        if (enable) begin
            for (int k = 0; k < NREQ; k++) begin
                sum = {1'b0, ptr} + (PW+1)'(k);
                if (sum >= (PW+1)'(NREQ)) begin
                    sum = sum - (PW+1)'(NREQ);
                end
                cand = sum[PW-1:0];
                if (!found && valid[cand]) begin
                    found       = 1'b1;
                    idx         = cand;
                    grant[cand] = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/serdes_tx_sched.sv
// Serializer word-slot scheduler: IDLE -> TRAIN commas -> round-robin data, one word per frame.
// Grants only in the last slot of a frame; word_out is held for a full frame starting at word_load.
module serdes_tx_sched
    import serdes_pkg::*;
#(
    parameter int               NREQ        = 4,
    parameter int               TRAIN_WORDS = 16,
    parameter logic [SYM_W-1:0] COMMA       = COMMA_RDN
) (
    input  logic                    TRANSCLK,
    input  logic                    RESET_L,
    input  logic                    tx_enable,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [SYM_W*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [SYM_W-1:0]        word_out,
    output logic                    word_load,
    output logic                    link_up,
    output logic                    frame_is_data
);
    localparam int                PW         = $clog2(NREQ);
    localparam logic [7:0]        TRAIN_LAST = 8'(TRAIN_WORDS - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(FRAME_LEN - 1);

    state_e            state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [7:0]        train_cnt_q, train_cnt_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [SYM_W-1:0]  word_out_q, word_out_d;
    logic              is_data_q, is_data_d;
    logic              word_load_q, word_load_d;

    logic              decide;
    logic              arb_en;
    logic [NREQ-1:0]   arb_grant;
    logic [PW-1:0]     arb_idx;
    logic              arb_found;

    assign decide = (slot_q == SLOT_LAST);
    assign arb_en = decide && (state_q == RUN) && tx_enable;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .valid  (req_valid),
        .ptr    (rr_ptr_q),
        .enable (arb_en),
        .grant  (arb_grant),
        .idx    (arb_idx),
        .found  (arb_found)
    );

    always_ff @(posedge TRANSCLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            train_cnt_q <= '0;
            rr_ptr_q    <= '0;
            word_out_q  <= COMMA;
            is_data_q   <= 1'b0;
            word_load_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            train_cnt_q <= train_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            word_out_q  <= word_out_d;
            is_data_q   <= is_data_d;
            word_load_q <= word_load_d;
        end
    end

    // Dropping tx_enable wins over every other transition at the decision edge.
    always_comb begin
        state_d = state_q;
        if (decide) begin
            if (!tx_enable) begin
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE:    state_d = TRAIN;
                    TRAIN:   state_d = (train_cnt_q == TRAIN_LAST) ? RUN : TRAIN;
                    RUN:     state_d = RUN;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        slot_d      = decide ? '0 : slot_q + 1'b1;
        word_load_d = decide;
        train_cnt_d = train_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        word_out_d  = word_out_q;
        is_data_d   = is_data_q;
        if (decide) begin
            word_out_d = COMMA;
            is_data_d  = 1'b0;
            if (state_q == IDLE) begin
                train_cnt_d = '0;
            end else if (state_q == TRAIN && train_cnt_q != 8'hFF) begin
                train_cnt_d = train_cnt_q + 8'd1;
            end
            if (arb_found) begin
                word_out_d = req_data[int'(arb_idx)*SYM_W +: SYM_W];
                is_data_d  = 1'b1;
                rr_ptr_d   = (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
            end
        end
    end

    assign req_ready     = arb_grant;
    assign word_out      = word_out_q;
    assign word_load     = word_load_q;
    assign frame_is_data = is_data_q;
    assign link_up       = (state_q == RUN);
endmodule
